systolic_array_nxm: RTL and testbench
=====================================

Name: systolic_array_nxm

Overview:
- Parametrised output-stationary systolic matrix-multiply engine: computes C = A × B with A ROWS×k_len, B k_len×COLS, C ROWS×COLS.
- Successor to the fixed 8×8 PE grid. It adds:
  - generic ROWS/COLS;
  - runtime inner dimension k_len;
  - internal input skewing;
  - a start/busy/done controller with accumulator clear;
  - valid/ready streaming in and row-by-row result readout.
- Sits between the operand buffers and the result writeback path.

Parameters:
- ROWS, 8, PE grid rows (≥1)
- COLS, 8, PE grid columns (≥1)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 32, signed accumulator width (≥ 2*DATA_WIDTH)
- K_MAX, 256, maximum inner dimension accepted in k_len

Ports:
- clk, input, 1, clock
- rst_n, input, 1, reset, synchronous, active-low
- start, input, 1, begin a job; sampled only in IDLE
- k_len, input, $clog2(K_MAX+1), inner dimension, captured on accepted start
- in_valid, input, 1, a_col/b_row beat valid
- in_ready, output, 1, beat accepted when in_valid && in_ready
- a_col, input, ROWS*DATA_WIDTH, column t of A; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- b_row, input, COLS*DATA_WIDTH, row t of B; element j at [j*DATA_WIDTH +: DATA_WIDTH]
- out_valid, output, 1, result row valid
- out_ready, input, 1, row consumed when out_valid && out_ready
- out_row, output, COLS*ACC_WIDTH, C[out_row_idx][j] at [j*ACC_WIDTH +: ACC_WIDTH]
- out_row_idx, output, $clog2(ROWS) (min 1), row index of out_row
- busy, output, 1, high in any state except IDLE
- done, output, 1, one-cycle pulse after the last row is consumed

Behaviour:
- Reset (rst_n low at posedge):
  - all outputs 0; state IDLE;
  - all accumulators, skew registers and PE A/B pipeline registers cleared to 0.
  - Reset mid-job aborts with no done pulse.
- States: IDLE, STREAM, DRAIN, OUTPUT. Counters: beat counter, drain counter, row counter.
- IDLE:
  - start=1 captures k_len and zeroes every accumulator in the same edge.
  - If k_len≠0, go to STREAM; if k_len=0, go to DRAIN, and all C rows read as 0.
  - start outside IDLE is ignored.
- STREAM:
  - in_ready=1. Each accepted beat t injects a_col/b_row into the skew stage.
  - A row i is delayed i cycles; B column j is delayed j cycles.
  - A moves right and B moves down one PE per cycle.
  - Beat t accepted in cycle c contributes A[i][t]*B[t][j] to PE(i,j) in cycle c+i+j+1.
  - Cycles with in_valid=0 inject zeros into both A and B (a bubble), so no accumulation error and no stall of the grid.
  - After the k_len-th accepted beat, go to DRAIN on the next edge.
- DRAIN:
  - in_ready=0; zeros are injected.
  - Lasts exactly ROWS+COLS-1 cycles, then go to OUTPUT.
  - Last accept in cycle c gives the first out_valid in cycle c+ROWS+COLS.
- OUTPUT:
  - out_valid=1; out_row_idx runs 0..ROWS-1.
  - out_row and out_row_idx are stable while out_valid && !out_ready.
  - On acceptance of row ROWS-1: done=1 for 1 cycle, out_valid=0, return to IDLE.
  - start in the done cycle is ignored; the next job can start the following cycle.
- Arithmetic:
  - Full-precision signed product (2*DATA_WIDTH), sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- Accumulators hold their value from the end of DRAIN until the next start.
- in_valid outside STREAM is ignored; no beat is consumed.

Test Plan:
- ROWS=COLS=8, k_len=8, A=identity, B[t][j]=t*8+j → rows out 0..7 with C=B; first out_valid exactly 15 cycles after the last accept.
- ROWS=2, COLS=3, k_len=2, A=[[1,2],[3,4]], B=[[5,6,7],[8,9,10]] → rows [21,24,27] then [47,54,61]; done after row 1.
- Same job with in_valid low on alternate cycles, then out_ready toggled 1-0-0-1 → identical results; out_row held during stalls; exactly one done pulse.
- DATA_WIDTH=16, k_len=4, all A=-32768, B=-32768 → each C=0x1_0000_0000 mod 2^32 = 0; A=-3, B=7, k_len=3 → each C=-63.
- start pulsed during STREAM and OUTPUT → ignored; k_len=0 → all rows 0 after ROWS+COLS-1 drain cycles.
- rst_n low for 1 cycle mid-STREAM → busy=0, no done; the next full job returns correct results with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_array_nxm_if.sv
// Stream-in / row-out bus of the output-stationary systolic array.
// slave is the array side, master is the operand/writeback side.
interface systolic_array_nxm_if #(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int K_MAX      = 256
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                       start;
   logic [KW-1:0]              k_len;
   logic                       in_valid;
   logic                       in_ready;
   logic [ROWS*DATA_WIDTH-1:0] a_col;
   logic [COLS*DATA_WIDTH-1:0] b_row;
   logic                       out_valid;
   logic                       out_ready;
   logic [COLS*ACC_WIDTH-1:0]  out_row;
   logic [RW-1:0]              out_row_idx;
   logic                       busy;
   logic                       done;

   modport master (
      output start, k_len, in_valid, a_col, b_row, out_ready,
      input  in_ready, out_valid, out_row, out_row_idx, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, a_col, b_row, out_ready,
      output in_ready, out_valid, out_row, out_row_idx, busy, done
   );
endinterface

// File: rtl/systolic_array_nxm.sv
// Output-stationary ROWSxCOLS systolic matmul C = A x B with skewed
// operand injection, runtime k_len and row-by-row result readout.
module systolic_array_nxm #(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int K_MAX      = 256
) (
   input logic                 clk,
   input logic                 rst_n,
   systolic_array_nxm_if.slave bus
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NW = $clog2(ROWS + COLS + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUTPUT} state_e;

   typedef logic signed [DATA_WIDTH-1:0] dat_t;
   typedef logic signed [ACC_WIDTH-1:0]  acc_t;

   state_e        state_q, state_d;
   logic [KW-1:0] klen_q, klen_d;
   logic [KW-1:0] beat_q, beat_d;
   logic [NW-1:0] drain_q, drain_d;
   logic [RW-1:0] row_q, row_d;
   logic          done_q, done_d;
   logic          clr;
   logic          accept;
   logic          acc_en;

   dat_t a_inj [ROWS];
   dat_t a_sk  [ROWS];
   dat_t b_inj [COLS];
   dat_t b_sk  [COLS];
   dat_t pa_q  [ROWS][COLS];
   dat_t pb_q  [ROWS][COLS];
   acc_t acc_q [ROWS][COLS];

   assign accept = bus.in_valid && (state_q == STREAM);
   assign acc_en = (state_q == STREAM) || (state_q == DRAIN);

   always_comb begin
      state_d = state_q;
      klen_d  = klen_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      row_d   = row_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // the done cycle is spent in IDLE but must not launch a job
            if (bus.start && !done_q) begin
               clr     = 1'b1;
               klen_d  = bus.k_len;
               beat_d  = '0;
               drain_d = '0;
               state_d = (bus.k_len == '0) ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == klen_q - 1'b1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == NW'(ROWS + COLS - 2)) begin
               state_d = OUTPUT;
               row_d   = '0;
            end
         end
         OUTPUT: begin
            if (bus.out_ready) begin
               if (row_q == RW'(ROWS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         klen_q  <= '0;
         beat_q  <= '0;
         drain_q <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   // bubbles and drain cycles push zeros so the grid never stalls
   always_comb begin
      for (int i = 0; i < ROWS; i++)
         a_inj[i] = accept ? dat_t'(bus.a_col[i*DATA_WIDTH +: DATA_WIDTH]) : '0;
      for (int j = 0; j < COLS; j++)
         b_inj[j] = accept ? dat_t'(bus.b_row[j*DATA_WIDTH +: DATA_WIDTH]) : '0;
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_ask
      if (i == 0) begin : g_nd
         assign a_sk[i] = a_inj[i];
      end else begin : g_d
         dat_t sk_q [i];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sk_q <= '{default: '0};
            end else begin
               sk_q[0] <= a_inj[i];
               for (int k = 1; k < i; k++) sk_q[k] <= sk_q[k-1];
            end
         end
         assign a_sk[i] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_bsk
      if (j == 0) begin : g_nd
         assign b_sk[j] = b_inj[j];
      end else begin : g_d
         dat_t sk_q [j];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sk_q <= '{default: '0};
            end else begin
               sk_q[0] <= b_inj[j];
               for (int k = 1; k < j; k++) sk_q[k] <= sk_q[k-1];
            end
         end
         assign b_sk[j] = sk_q[j-1];
      end
   end

   function automatic acc_t mac(input acc_t acc, input dat_t a, input dat_t b);
      logic signed [2*DATA_WIDTH-1:0] p;
      p = a * b;
      return acc + ACC_WIDTH'(p);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pa_q  <= '{default: '0};
         pb_q  <= '{default: '0};
         acc_q <= '{default: '0};
      end else begin
         for (int i = 0; i < ROWS; i++) begin
            pa_q[i][0] <= a_sk[i];
            for (int j = 1; j < COLS; j++) pa_q[i][j] <= pa_q[i][j-1];
         end
         for (int j = 0; j < COLS; j++) begin
            pb_q[0][j] <= b_sk[j];
            for (int i = 1; i < ROWS; i++) pb_q[i][j] <= pb_q[i-1][j];
         end
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               if (clr)
                  acc_q[i][j] <= '0;
               else if (acc_en)
                  acc_q[i][j] <= mac(acc_q[i][j], pa_q[i][j], pb_q[i][j]);
            end
         end
      end
   end

   always_comb begin
      bus.out_row = '0;
      for (int j = 0; j < COLS; j++)
         bus.out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
   end

   assign bus.in_ready    = (state_q == STREAM);
   assign bus.out_valid   = (state_q == OUTPUT);
   assign bus.out_row_idx = row_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
endmodule

// File: tb/tb_systolic_array_nxm.sv
// Directed bench: 2x3 array for handshake/arithmetic cases and a
// default 8x8 array for the identity job.
module tb_systolic_array_nxm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_array_nxm_if #(.ROWS(2), .COLS(3)) b2();
   systolic_array_nxm_if b8();

   systolic_array_nxm #(.ROWS(2), .COLS(3)) d23 (
      .clk(clk), .rst_n(rst_n), .bus(b2)
   );
   systolic_array_nxm d88 (
      .clk(clk), .rst_n(rst_n), .bus(b8)
   );

   int errs = 0;
   int chks = 0;
   int dn2 = 0;
   int a23 [2][4];
   int b23 [4][3];
   int e23 [2][3];

   always @(negedge clk) if (b2.done) dn2++;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      chks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full job on the 2x3 array using a23/b23/e23
   task automatic job23(input int k, input bit bub, input bit stall,
                        input bit poke, input string nm);
      int t, cnt, lat, r, p, d0;
      bit acc, rdy;
      logic [3:0] pat;
      logic [31:0] ev;
      pat = 4'b1001;
      d0 = dn2;
      b2.start = 1'b1;
      b2.k_len = 9'(k);
      tick();
      b2.start = 1'b0;
      chk({"busy_", nm}, b2.busy, 1);
      t = 0;
      cnt = 0;
      while (t < k && cnt < 64) begin
         b2.in_valid = bub ? ((cnt % 2) == 1) : 1'b1;
         for (int i = 0; i < 2; i++) b2.a_col[i*16 +: 16] = 16'(a23[i][t]);
         for (int j = 0; j < 3; j++) b2.b_row[j*16 +: 16] = 16'(b23[t][j]);
         b2.start = poke && (cnt == 1);
         b2.k_len = poke ? 9'd1 : 9'(k);
         acc = b2.in_valid && b2.in_ready;
         tick();
         if (acc) t++;
         cnt++;
      end
      b2.start = 1'b0;
      chk({"beats_", nm}, t, k);
      b2.in_valid = poke;
      b2.a_col = '1;
      b2.b_row = '1;
      chk({"rdy_drain_", nm}, b2.in_ready, 0);
      lat = 0;
      while (!b2.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      b2.in_valid = 1'b0;
      chk({"lat_", nm}, lat, 4);
      r = 0;
      p = 0;
      while (r < 2 && p < 50) begin
         rdy = stall ? pat[p % 4] : 1'b1;
         b2.out_ready = rdy;
         b2.start = poke && (p == 0);
         chk($sformatf("vld_%s_p%0d", nm, p), b2.out_valid, 1);
         chk($sformatf("idx_%s_p%0d", nm, p), b2.out_row_idx, r);
         for (int j = 0; j < 3; j++) begin
            ev = e23[r][j];
            chk($sformatf("c%0d%0d_%s_p%0d", r, j, nm, p),
                b2.out_row[j*32 +: 32], ev);
         end
         tick();
         if (rdy) r++;
         p++;
      end
      b2.out_ready = 1'b0;
      b2.start = 1'b1;
      chk({"done_", nm}, b2.done, 1);
      chk({"vld_end_", nm}, b2.out_valid, 0);
      chk({"busy_end_", nm}, b2.busy, 0);
      tick();
      b2.start = 1'b0;
      chk({"done_off_", nm}, b2.done, 0);
      chk({"nostart_", nm}, b2.busy, 0);
      chk({"done_cnt_", nm}, dn2 - d0, 1);
   endtask

   initial begin
      int lat, d0;
      logic [31:0] ev;
      b2.start = 0; b2.k_len = 0; b2.in_valid = 0; b2.out_ready = 0;
      b2.a_col = '0; b2.b_row = '0;
      b8.start = 0; b8.k_len = 0; b8.in_valid = 0; b8.out_ready = 0;
      b8.a_col = '0; b8.b_row = '0;
      repeat (3) tick();
      chk("rst_busy", b2.busy, 0);
      chk("rst_done", b2.done, 0);
      chk("rst_vld", b2.out_valid, 0);
      chk("rst_rdy", b2.in_ready, 0);
      chk("rst_row", b2.out_row, 0);
      chk("rst_idx", b2.out_row_idx, 0);
      chk("rst_busy8", b8.busy, 0);
      rst_n = 1'b1;
      tick();

      a23 = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}};
      b23 = '{'{5, 6, 7}, '{8, 9, 10}, '{0, 0, 0}, '{0, 0, 0}};
      e23 = '{'{21, 24, 27}, '{47, 54, 61}};
      job23(2, 0, 0, 0, "basic");
      job23(2, 1, 1, 0, "bubble");
      job23(2, 1, 0, 1, "poke");

      a23 = '{'{-32768, -32768, -32768, -32768},
              '{-32768, -32768, -32768, -32768}};
      b23 = '{'{-32768, -32768, -32768}, '{-32768, -32768, -32768},
              '{-32768, -32768, -32768}, '{-32768, -32768, -32768}};
      e23 = '{'{0, 0, 0}, '{0, 0, 0}};
      job23(4, 0, 0, 0, "wrap");

      a23 = '{'{-3, -3, -3, 0}, '{-3, -3, -3, 0}};
      b23 = '{'{7, 7, 7}, '{7, 7, 7}, '{7, 7, 7}, '{0, 0, 0}};
      e23 = '{'{-63, -63, -63}, '{-63, -63, -63}};
      job23(3, 0, 0, 0, "neg");

      e23 = '{'{0, 0, 0}, '{0, 0, 0}};
      job23(0, 0, 0, 0, "k0");

      // abort mid-stream, then a clean job must show no residue
      a23 = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}};
      b23 = '{'{5, 6, 7}, '{8, 9, 10}, '{0, 0, 0}, '{0, 0, 0}};
      d0 = dn2;
      b2.start = 1'b1;
      b2.k_len = 9'd2;
      tick();
      b2.start = 1'b0;
      b2.in_valid = 1'b1;
      b2.a_col = {16'd3, 16'd1};
      b2.b_row = {16'd7, 16'd6, 16'd5};
      tick();
      b2.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", b2.busy, 0);
      chk("abort_rdy", b2.in_ready, 0);
      repeat (8) tick();
      chk("abort_nodone", dn2 - d0, 0);
      e23 = '{'{21, 24, 27}, '{47, 54, 61}};
      job23(2, 0, 0, 0, "after_rst");

      // 8x8 identity job: C must equal B
      b8.start = 1'b1;
      b8.k_len = 9'd8;
      tick();
      b8.start = 1'b0;
      for (int t = 0; t < 8; t++) begin
         b8.in_valid = 1'b1;
         b8.a_col = '0;
         b8.a_col[t*16 +: 16] = 16'd1;
         for (int j = 0; j < 8; j++) b8.b_row[j*16 +: 16] = 16'(t * 8 + j);
         chk($sformatf("rdy8_t%0d", t), b8.in_ready, 1);
         tick();
      end
      b8.in_valid = 1'b0;
      lat = 0;
      while (!b8.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("lat8", lat, 15);
      b8.out_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         chk($sformatf("vld8_r%0d", r), b8.out_valid, 1);
         chk($sformatf("idx8_r%0d", r), b8.out_row_idx, r);
         for (int j = 0; j < 8; j++) begin
            ev = 32'(r * 8 + j);
            chk($sformatf("c8_%0d%0d", r, j), b8.out_row[j*32 +: 32], ev);
         end
         tick();
      end
      b8.out_ready = 1'b0;
      chk("done8", b8.done, 1);
      chk("vld8_end", b8.out_valid, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
